pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_BUS_WIDTH, default 32, meaning the PC and address width.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL have parameter EXC_VECTOR, default 32'h0000_0180, meaning the redirect target on misaligned JR.
REQ-004 The block SHALL use a single clock, and reset SHALL be asynchronous and active-low: clk  in  1  clock, rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 imem_req  out  1  fetch request, held until acknowledged.
REQ-007 imem_addr  out  DATA_BUS_WIDTH  fetch address, equal to pc.
REQ-008 imem_ack  in  1  instruction memory acknowledges the current request.
REQ-009 stall  in  1  downstream cannot accept a new instruction.
REQ-010 branch_taken  in  1  one-cycle pulse: conditional branch resolved taken.
REQ-011 branch_imm  in  16  branch offset, in words.
REQ-012 jump  in  1  one-cycle pulse: J/JAL.
REQ-013 jump_index  in  26  jump instruction index field.
REQ-014 jr  in  1  one-cycle pulse: JR/JALR.
REQ-015 jr_target  in  DATA_BUS_WIDTH  register jump target.
REQ-016 pc_out  out  DATA_BUS_WIDTH  PC of the delivered instruction.
REQ-017 pc_plus4  out  DATA_BUS_WIDTH  pc_out + 4.
REQ-018 instr_valid  out  1  one-cycle pulse: an instruction was delivered.
REQ-019 misalign  out  1  one-cycle pulse: misaligned JR trapped.

Function
REQ-020 The FSM SHALL have the states IDLE, FETCH and HOLD; IDLE SHALL last exactly one cycle after reset release and then go to FETCH.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL be stable until imem_ack.
REQ-022 On imem_ack in FETCH, with no redirect: instr_valid=1 next cycle, pc_out=pc, pc_plus4=pc+4, pc<=pc+4.
REQ-023 On ack with stall=0, the FSM SHALL stay in FETCH; on ack with stall=1, the FSM SHALL go to HOLD with imem_req=0 and leave HOLD for FETCH on the first cycle with stall=0.
REQ-024 When not acknowledging, stall SHALL NOT affect FETCH; a request in flight SHALL always complete.
REQ-025 The branch target SHALL be pc_plus4 + (sign_extend(branch_imm) << 2), computed modulo 2^DATA_BUS_WIDTH, with wrap-around allowed.
REQ-026 The jump target SHALL be {pc_plus4[31:28], jump_index, 2'b00}.
REQ-027 Redirect priority SHALL be jr > jump > branch_taken when several pulse together.
REQ-028 A redirect in IDLE or HOLD SHALL load pc with the target on the next edge.
REQ-029 A redirect in FETCH without ack SHALL be latched into a one-entry pending register; the next ack SHALL be squashed (instr_valid=0) and pc SHALL load the pending target.
REQ-030 A redirect in the same cycle as imem_ack SHALL squash the returned instruction and load pc with the target.
REQ-031 A second redirect while one is pending SHALL overwrite the pending target.

Reset
REQ-032 On rst_n=0, the block SHALL asynchronously set: state=IDLE, pc=RESET_PC, pending cleared, imem_req=0, instr_valid=0, misalign=0, pc_out=0, pc_plus4=0.
REQ-033 Reset mid-fetch SHALL abandon the request; any imem_ack arriving in IDLE SHALL be ignored.

Configuration
REQ-034 With PC_MISALIGN_TRAP_EN defined, jr with jr_target[1:0]!=0 SHALL pulse misalign for one cycle and redirect to EXC_VECTOR instead of jr_target.
REQ-035 Without PC_MISALIGN_TRAP_EN, jr_target[1:0] SHALL be forced to 2'b00 and misalign SHALL be tied to 0.

Verification
REQ-036 Reset release, ack every cycle -> imem_addr 0x0, 0x4, 0x8; instr_valid pulses with pc_out 0x0, 0x4.
REQ-037 Branch_taken, imm=16'hFFFF, pc_plus4=0x104 -> next imem_addr 0x100; the in-flight ack is squashed.
REQ-038 Jump, index=26'h0000040, pc_plus4=0x4000_0010 -> imem_addr 0x4000_0100.
REQ-039 Stall=1 at ack -> HOLD, imem_req=0 for 3 stall cycles, resume at pc+4; jr during HOLD to 0x200 -> next fetch 0x200.
REQ-040 jr_target=0x202 -> with macro: misalign=1, fetch 0x180; without macro: fetch 0x200, misalign=0.
REQ-041 rst_n low while imem_req=1 -> imem_req=0 immediately; after release, first fetch is RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Instruction fetch sequencer. It owns the program counter, issues fetch
// requests to the instruction memory, delivers fetched instructions
// downstream, and applies control-flow redirects (branch, jump, jump-register).
//
// The FSM has three states:
//   IDLE  : lasts one cycle after reset release. imem_ack is ignored here.
//   FETCH : imem_req is high and imem_addr (= pc) is held until imem_ack.
//   HOLD  : entered when the downstream stalls on an ack. No request is issued.
//           Leaves for FETCH on the first cycle with stall low.
//
// A redirect seen in FETCH while a request is still outstanding cannot move
// the address, because the request must complete. The target is parked in a
// one-entry pending register instead. The next ack is squashed and pc loads the
// parked target. A later redirect overwrites the parked target.
//
// Optional feature (macro PC_MISALIGN_TRAP_EN):
//   defined   : a JR with jr_target[1:0] != 0 pulses misalign for one cycle and
//               redirects to EXC_VECTOR.
//   undefined : jr_target[1:0] is forced to 2'b00 and misalign stays 0.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   imem_req/addr/ack     instruction memory fetch handshake (addr == pc)
//   stall                 downstream cannot accept a new instruction
//   branch_taken/imm      taken conditional branch, word offset
//   jump/jump_index       J/JAL with its instruction index field
//   jr/jr_target          JR/JALR with its register target
//   pc_out, pc_plus4      PC of the delivered instruction, and that PC + 4
//   instr_valid           one-cycle pulse when an instruction is delivered
//   misalign              one-cycle pulse when a misaligned JR is trapped
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned                    DATA_BUS_WIDTH = 32,
  parameter logic [DATA_BUS_WIDTH-1:0]      RESET_PC       = 32'h0000_0000,
  parameter logic [DATA_BUS_WIDTH-1:0]      EXC_VECTOR     = 32'h0000_0180
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      imem_req,
  output logic [DATA_BUS_WIDTH-1:0] imem_addr,
  input  logic                      imem_ack,
  input  logic                      stall,
  input  logic                      branch_taken,
  input  logic [15:0]               branch_imm,
  input  logic                      jump,
  input  logic [25:0]               jump_index,
  input  logic                      jr,
  input  logic [DATA_BUS_WIDTH-1:0] jr_target,
  output logic [DATA_BUS_WIDTH-1:0] pc_out,
  output logic [DATA_BUS_WIDTH-1:0] pc_plus4,
  output logic                      instr_valid,
  output logic                      misalign
);

  localparam int unsigned DW = DATA_BUS_WIDTH;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] pc_inc;
  logic          pend_valid_q, pend_valid_d;
  logic [DW-1:0] pend_tgt_q, pend_tgt_d;
  logic          deliver;

  // ---------------------------------------------------------------------------
  // Redirect targets. Branch and jump targets are relative to the instruction
  // just delivered (pc_plus4), because that is the one the downstream resolved.
  // ---------------------------------------------------------------------------
  logic          redirect;
  logic [DW-1:0] branch_tgt, jump_tgt, jr_tgt, redirect_tgt;
  logic          jr_trap;

  assign pc_inc     = pc_q + DW'(4);
  assign redirect   = jr | jump | branch_taken;
  // The sum is DW bits wide, so it wraps modulo 2^DW.
  assign branch_tgt = pc_plus4 + {{(DW-18){branch_imm[15]}}, branch_imm, 2'b00};
  assign jump_tgt   = {pc_plus4[DW-1:28], jump_index, 2'b00};

`ifdef PC_MISALIGN_TRAP_EN
  assign jr_trap = jr && (jr_target[1:0] != 2'b00);
  assign jr_tgt  = (jr_target[1:0] != 2'b00) ? EXC_VECTOR : jr_target;
`else
  assign jr_trap = 1'b0;
  assign jr_tgt  = jr_target & ~DW'(3);
`endif

  // jr has the highest priority, then jump, then branch.
  assign redirect_tgt = jr   ? jr_tgt   :
                        jump ? jump_tgt : branch_tgt;

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;

  // ---------------------------------------------------------------------------
  // Next-state and next-pc logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first. This means no path
    // leaves a signal unassigned, so no latch is inferred.
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_tgt_d   = pend_tgt_q;
    deliver      = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) pc_d = redirect_tgt;
      end

      FETCH: begin
        if (imem_ack) begin
          state_d      = stall ? HOLD : FETCH;
          pend_valid_d = 1'b0;
          if (redirect) begin
            pc_d = redirect_tgt;           // same-cycle redirect squashes
          end else if (pend_valid_q) begin
            pc_d = pend_tgt_q;             // parked redirect squashes
          end else begin
            deliver = 1'b1;
            pc_d    = pc_inc;
          end
        end else if (redirect) begin
          // The address must stay put until ack, so park the target.
          pend_valid_d = 1'b1;
          pend_tgt_d   = redirect_tgt;
        end
      end

      HOLD: begin
        if (!stall)   state_d = FETCH;
        if (redirect) pc_d    = redirect_tgt;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, pc and pending register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_tgt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // register then samples pre-edge values, whatever the statement order.
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_tgt_q   <= pend_tgt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Delivery outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
      pc_out      <= '0;
      pc_plus4    <= '0;
    end else begin
      instr_valid <= deliver;
      misalign    <= jr_trap;
      if (deliver) begin
        pc_out   <= pc_q;
        pc_plus4 <= pc_inc;
      end
    end
  end

endmodule
